// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : RV32I instruction-fetch stage. Holds the PC, drives the
//             instruction-memory address and presents PC, PC+4, the fetched
//             instruction, an ECALL flag and a branch prediction to IF/ID.
//             Conditional branches are predicted by a PC-indexed table of
//             2-bit saturating counters; JAL is always predicted taken.
//  Ports    : clk, rst_n (async, active-low)
//             stall, redirect, redirect_pc          - PC control from hazard/EX
//             bht_update, bht_update_pc/_taken      - predictor training from EX
//             imem_rdata / imem_addr                - instruction memory
//             pc_IF, pc_plus4_IF, instruction_IF,
//             ecall_IF, predict_taken_IF            - to IF/ID register
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BHT_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        bht_update,
    input  logic [31:0] bht_update_pc,
    input  logic        bht_update_taken,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_IF,
    output logic [31:0] pc_plus4_IF,
    output logic [31:0] instruction_IF,
    output logic        ecall_IF,
    output logic        predict_taken_IF
);

    localparam int          c_IDX_W      = $clog2(BHT_ENTRIES);
    localparam logic [31:0] c_NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] c_ECALL      = 32'h0000_0073;
    localparam logic [6:0]  c_OP_BRANCH  = 7'b1100011;
    localparam logic [6:0]  c_OP_JAL     = 7'b1101111;
    localparam logic [1:0]  c_CNT_RESET  = 2'b01;

    localparam logic [0:0]  c_ST_RUN     = 1'b0;
    localparam logic [0:0]  c_ST_HALT    = 1'b1;

    logic [31:0]        r_pc;
    logic [0:0]         r_state;
    logic [1:0]         r_bht [BHT_ENTRIES];

    logic [31:0]        w_pc_next;
    logic [0:0]         w_state_next;
    logic [c_IDX_W-1:0] w_idx;
    logic [c_IDX_W-1:0] w_upd_idx;
    logic [1:0]         w_upd_cnt;
    logic [1:0]         w_upd_cnt_next;
    logic               w_run;
    logic               w_is_branch;
    logic               w_is_jal;
    logic               w_is_ecall;
    logic               w_predict;
    logic [31:0]        w_b_imm;
    logic [31:0]        w_j_imm;
    logic [31:0]        w_target;
    logic [31:0]        w_pc_plus4;

    // Only the index slice of the training PC selects a counter.
    logic               w_unused_upd_bits;
    assign w_unused_upd_bits = &{bht_update_pc[31:c_IDX_W+2], bht_update_pc[1:0]};

    // ------------------------------------------------------------------------
    // Decode and prediction (combinational from PC, state, table, imem_rdata)
    // ------------------------------------------------------------------------
    assign w_run       = (r_state == c_ST_RUN);
    assign w_idx       = r_pc[c_IDX_W+1:2];
    assign w_upd_idx   = bht_update_pc[c_IDX_W+1:2];
    assign w_is_branch = (imem_rdata[6:0] == c_OP_BRANCH);
    assign w_is_jal    = (imem_rdata[6:0] == c_OP_JAL);
    assign w_is_ecall  = (imem_rdata == c_ECALL);

    assign w_b_imm = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                      imem_rdata[30:25], imem_rdata[11:8], 1'b0};
    assign w_j_imm = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                      imem_rdata[20], imem_rdata[30:21], 1'b0};

    assign w_target   = r_pc + (w_is_jal ? w_j_imm : w_b_imm);
    assign w_pc_plus4 = r_pc + 32'd4;

    // Lookup reads the registered counter, so a same-cycle update to the same
    // entry is not visible until the next cycle.
    assign w_predict = w_run && (w_is_jal || (w_is_branch && r_bht[w_idx][1]));

    assign imem_addr        = r_pc;
    assign pc_IF            = r_pc;
    assign pc_plus4_IF      = w_pc_plus4;
    assign instruction_IF   = w_run ? imem_rdata : c_NOP_INSTR;
    assign ecall_IF         = w_run && w_is_ecall;
    assign predict_taken_IF = w_predict;

    // ------------------------------------------------------------------------
    // Next PC / state
    // ------------------------------------------------------------------------
    always_comb begin
        w_pc_next    = r_pc;
        w_state_next = r_state;
        if (redirect) begin
            w_pc_next    = redirect_pc;
            w_state_next = c_ST_RUN;
        end else if (stall) begin
            w_pc_next    = r_pc;
        end else if (r_state == c_ST_HALT) begin
            w_pc_next    = r_pc;
        end else begin
            w_pc_next = w_predict ? w_target : w_pc_plus4;
            // ECALL is never predicted taken, so the PC parks at ECALL+4.
            if (w_is_ecall) begin
                w_state_next = c_ST_HALT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_state <= c_ST_RUN;
        end else begin
            r_pc    <= w_pc_next;
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Counter table training (independent of stall/redirect/state)
    // ------------------------------------------------------------------------
    assign w_upd_cnt = r_bht[w_upd_idx];

    always_comb begin
        w_upd_cnt_next = w_upd_cnt;
        if (bht_update_taken) begin
            if (w_upd_cnt != 2'b11) begin
                w_upd_cnt_next = w_upd_cnt + 2'b01;
            end
        end else begin
            if (w_upd_cnt != 2'b00) begin
                w_upd_cnt_next = w_upd_cnt - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= c_CNT_RESET;
            end
        end else if (bht_update) begin
            r_bht[w_upd_idx] <= w_upd_cnt_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Self-checking bench for fetch_stage. A behavioural model of the
//             fetch rules (PC, halt flag, integer counter table) predicts every
//             output each cycle; directed steps are followed by random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          ENTRIES  = 64;
    localparam logic [31:0] ADDI     = 32'h0000_0013;
    localparam logic [31:0] ECALL    = 32'h0000_0073;
    localparam logic [31:0] JAL_P16  = 32'h0100_006F;
    localparam logic [31:0] BEQ_M8   = 32'hFE00_0CE3;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        bht_update;
    logic [31:0] bht_update_pc;
    logic        bht_update_taken;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] pc_IF;
    logic [31:0] pc_plus4_IF;
    logic [31:0] instruction_IF;
    logic        ecall_IF;
    logic        predict_taken_IF;

    fetch_stage #(.RESET_PC(RESET_PC), .BHT_ENTRIES(ENTRIES)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .bht_update       (bht_update),
        .bht_update_pc    (bht_update_pc),
        .bht_update_taken (bht_update_taken),
        .imem_rdata       (imem_rdata),
        .imem_addr        (imem_addr),
        .pc_IF            (pc_IF),
        .pc_plus4_IF      (pc_plus4_IF),
        .instruction_IF   (instruction_IF),
        .ecall_IF         (ecall_IF),
        .predict_taken_IF (predict_taken_IF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_halt;
    int          m_cnt [ENTRIES];

    task automatic model_reset();
        m_pc   = RESET_PC;
        m_halt = 1'b0;
        for (int i = 0; i < ENTRIES; i++) m_cnt[i] = 1;
    endtask

    function automatic int index_of(input logic [31:0] pc);
        int unsigned u;
        u = pc;
        return int'((u / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [31:0] ins);
        int unsigned u;
        int          imm;
        u = ins;
        if ((u & 127) == 32'h6F) begin
            imm = int'((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
                       (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1));
            if (imm >= (1 << 20)) imm = imm - (1 << 21);
        end else begin
            imm = int'((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                       (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1));
            if (imm >= 4096) imm = imm - 8192;
        end
        return pc + 32'(imm);
    endfunction

    function automatic bit ref_predict(input logic [31:0] ins);
        int unsigned op;
        op = ins & 127;
        if (m_halt) return 1'b0;
        if (op == 32'h6F) return 1'b1;
        if (op == 32'h63) return m_cnt[index_of(m_pc)] >= 2;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("pc_IF",        pc_IF,          m_pc);
        chk("imem_addr",    imem_addr,      m_pc);
        chk("pc_plus4",     pc_plus4_IF,    m_pc + 32'd4);
        chk("instruction",  instruction_IF, m_halt ? ADDI : imem_rdata);
        chk("ecall",        {31'd0, ecall_IF},
                            {31'd0, (!m_halt && imem_rdata == ECALL)});
        chk("predict",      {31'd0, predict_taken_IF}, {31'd0, ref_predict(imem_rdata)});
    endtask

    // One clock cycle: drive, check mid-cycle, clock, advance the model.
    task automatic step(input logic [31:0] ins, input logic st, input logic rd,
                        input logic [31:0] rpc, input logic up,
                        input logic [31:0] upc, input logic ut);
        logic [31:0] npc;
        bit          nhalt;
        int          uidx;
        imem_rdata       = ins;
        stall            = st;
        redirect         = rd;
        redirect_pc      = rpc;
        bht_update       = up;
        bht_update_pc    = upc;
        bht_update_taken = ut;
        #3;
        check_outputs();
        npc   = m_pc;
        nhalt = m_halt;
        if (rd) begin
            npc   = rpc;
            nhalt = 1'b0;
        end else if (!st && !m_halt) begin
            npc = ref_predict(ins) ? ref_target(m_pc, ins) : m_pc + 32'd4;
            if (ins == ECALL) nhalt = 1'b1;
        end
        @(posedge clk);
        m_pc   = npc;
        m_halt = nhalt;
        if (up) begin
            uidx = index_of(upc);
            if (ut) m_cnt[uidx] = (m_cnt[uidx] < 3) ? m_cnt[uidx] + 1 : 3;
            else    m_cnt[uidx] = (m_cnt[uidx] > 0) ? m_cnt[uidx] - 1 : 0;
        end
        #1;
    endtask

    task automatic run(input logic [31:0] ins);
        step(ins, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic jump(input logic [31:0] target);
        step(ADDI, 1'b0, 1'b1, target, 1'b0, 32'd0, 1'b0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0, 1, 2: return {r[31:7], 7'h13};
            3, 4, 5: return {r[31:7], 7'h63};
            6:       return {r[31:7], 7'h6F};
            7:       return {r[31:7], 7'h67};
            8:       return ($urandom_range(0, 2) == 0) ? ECALL : ADDI;
            default: return r;
        endcase
    endfunction

    task automatic random_cycles(input int n);
        logic [31:0] rpc;
        logic [31:0] upc;
        logic        rd;
        logic        st;
        logic        up;
        for (int i = 0; i < n; i++) begin
            rd  = ($urandom_range(0, 7) == 0);
            st  = ($urandom_range(0, 5) == 0);
            up  = ($urandom_range(0, 2) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = rpc | 32'hFFFF_FF00;
            rpc = rpc & 32'hFFFF_FFFC;
            upc = ($urandom_range(0, 1) == 0) ? m_pc : ($urandom & 32'hFFFF_FFFC);
            step(rand_instr(), st, rd, rpc, up, upc, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        bht_update = 1'b0; bht_update_pc = 32'd0; bht_update_taken = 1'b0;
        imem_rdata = ADDI;
        model_reset();
        #3;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential stream from reset
        for (int i = 0; i < 4; i++) run(ADDI);
        chk("seq_pc", pc_IF, 32'h10);

        // JAL +16 at 0x20
        jump(32'h20);
        run(JAL_P16);
        chk("jal_next", pc_IF, 32'h30);

        // BEQ -8 at 0x40: weak-NT, then train to strong-T
        jump(32'h40);
        run(BEQ_M8);
        chk("beq_nt_next", pc_IF, 32'h44);
        step(ADDI, 1'b0, 1'b0, 32'd0, 1'b1, 32'h40, 1'b1);
        step(ADDI, 1'b0, 1'b0, 32'd0, 1'b1, 32'h40, 1'b1);
        jump(32'h40);
        run(BEQ_M8);
        chk("beq_t_next", pc_IF, 32'h38);
        // Saturate low, then one taken step must leave it weak-NT
        for (int i = 0; i < 4; i++) step(ADDI, 1'b0, 1'b0, 32'd0, 1'b1, 32'h40, 1'b0);
        step(ADDI, 1'b0, 1'b0, 32'd0, 1'b1, 32'h40, 1'b1);
        jump(32'h40);
        run(BEQ_M8);
        chk("beq_sat_next", pc_IF, 32'h44);

        // Stall with redirect in the middle
        jump(32'h10);
        step(ADDI, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        chk("stall_hold", pc_IF, 32'h10);
        step(ADDI, 1'b1, 1'b1, 32'h80, 1'b0, 32'd0, 1'b0);
        chk("stall_redirect", pc_IF, 32'h80);
        step(ADDI, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        run(ADDI);
        chk("stall_release", pc_IF, 32'h84);

        // ECALL halt and resume
        jump(32'h50);
        run(ECALL);
        chk("ecall_park", pc_IF, 32'h54);
        run(JAL_P16);
        run(ECALL);
        run(BEQ_M8);
        step(ADDI, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        chk("halt_hold", pc_IF, 32'h54);
        chk("halt_nop", instruction_IF, ADDI);
        jump(32'h100);
        chk("halt_exit", pc_IF, 32'h100);

        // Same-cycle lookup and update of one entry
        step(ADDI, 1'b0, 1'b0, 32'd0, 1'b1, 32'h60, 1'b1);
        jump(32'h60);
        step(BEQ_M8, 1'b0, 1'b0, 32'd0, 1'b1, 32'h60, 1'b0);
        chk("bypass_old", pc_IF, 32'h58);
        jump(32'h60);
        run(BEQ_M8);
        chk("bypass_new", pc_IF, 32'h64);

        // Random traffic
        random_cycles(400);

        // Asynchronous reset mid-cycle drops all training
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset_pc", pc_IF, RESET_PC);
        @(negedge clk);
        rst_n = 1'b1;
        random_cycles(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage RV32I core, directly upstream of the IF/ID pipeline register. Holds the program counter, drives the instruction-memory address, and presents PC, PC+4, the fetched instruction, an ECALL flag and a branch-taken prediction to IF/ID. Prediction uses a PC-indexed table of 2-bit saturating counters for conditional branches; JAL is always predicted taken. EX-stage resolution trains the table and redirects the PC on a mispredict.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BHT_ENTRIES, 64, counter-table depth; power of two, ≥2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- stall  input  1  hazard-unit hold: PC keeps its value.
- redirect  input  1  EX-stage mispredict/jump correction.
- redirect_pc  input  32  correct next PC when redirect=1.
- bht_update  input  1  EX resolved a conditional branch this cycle.
- bht_update_pc  input  32  PC of the resolved branch.
- bht_update_taken  input  1  actual outcome of the resolved branch.
- imem_rdata  input  32  instruction at imem_addr (combinational read, same cycle).
- imem_addr  output  32  fetch address; equals pc_IF.
- pc_IF  output  32  current PC.
- pc_plus4_IF  output  32  pc_IF + 4, modulo 2^32.
- instruction_IF  output  32  fetched instruction, or NOP_INSTR_HEX (32'h0000_0013) while halted.
- ecall_IF  output  1  instruction_IF == 32'h0000_0073.
- predict_taken_IF  output  1  fetch chose the predicted target as next PC.

## Operation
- Index: idx = pc[2+log2(BHT_ENTRIES)-1 : 2]; update index from bht_update_pc, same slice.
- Counters: 2 bits, 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. All reset to 01. Update: taken → +1 saturating at 11; not-taken → −1 saturating at 00.
- Prediction, from imem_rdata while in RUN:
  - opcode 1100011 (B-type): taken if counter[idx][1]=1; target = pc + sext B-immediate {imm[12:1],0}.
  - opcode 1101111 (JAL): always taken; target = pc + sext J-immediate {imm[20:1],0}.
  - All other opcodes, including JALR, predict not-taken.
  - Target arithmetic is 32-bit, wraps modulo 2^32.
- State machine:
  - RUN: normal fetch.
  - HALT: entered at the clock edge that fetches an ECALL in RUN with stall=0 and redirect=0. PC holds, instruction_IF = NOP, ecall_IF = 0, predict_taken_IF = 0. Exit to RUN only on redirect.
- Next-PC priority, highest first:
  1. redirect → redirect_pc; state := RUN.
  2. stall → hold PC and state.
  3. HALT → hold PC.
  4. predicted taken → target.
  5. otherwise → pc + 4.
- ECALL in RUN: ecall_IF=1 for the cycle it is presented; next PC = pc+4, captured into PC while in HALT state. PC+4 is held until redirect.
- predict_taken_IF mirrors the choice made in step 4. It is still driven from the current instruction while stall or redirect is high; IF/ID flushing covers that case.
- BHT update is independent of stall, redirect and state; it writes at the clock edge.
- Same-cycle update and lookup of the same index: lookup sees the pre-update counter.

## Timing
- Reset (asynchronous): PC=RESET_PC, state=RUN, all counters=01. Outputs then follow combinationally: imem_addr=pc_IF=RESET_PC, pc_plus4_IF=RESET_PC+4, instruction_IF=imem_rdata, ecall_IF and predict_taken_IF derived from it.
- All outputs are combinational from PC, state, counters and imem_rdata. There is no extra latency inside the stage; IF/ID adds one cycle.
- redirect asserted in cycle N → pc_IF = redirect_pc in cycle N+1.
- Training latency: a bht_update in cycle N affects predictions from cycle N+1.
- stall held k cycles → pc_IF constant for those k cycles, then advances.
- Reset asserted mid-operation: immediate return to reset values; counter training is lost.

## Test plan
- Reset release with RESET_PC=0 and sequential ADDI stream → pc_IF 0,4,8,C on successive cycles; predict_taken_IF=0 throughout.
- JAL +16 at PC 0x20 (imem_rdata 32'h0100_006F) → predict_taken_IF=1; next pc_IF=0x30.
- BEQ −8 at PC 0x40 with counter 01 → not taken, next PC 0x44. Then two bht_update taken for 0x40 → counter 11; refetch 0x40 → next PC 0x38. Four not-taken updates → counter saturates at 00.
- stall=1 for 3 cycles at PC 0x10, with redirect to 0x80 in the second stall cycle → next pc_IF=0x80 (redirect wins over stall).
- ECALL fetched at 0x50 → ecall_IF=1 for one cycle. Afterwards pc_IF=0x54, instruction_IF=0x0000_0013, ecall_IF=0 indefinitely. redirect to 0x100 → RUN resumes at 0x100.
- Simultaneous bht_update (not-taken) and fetch of the same branch index with counter 10 → prediction uses 10 (taken); next lookup of that index sees 01.
